xain_apf_video_adapter: RTL and testbench

Converts the Xain'd Sleena core video stream (8-bit RGB after the 4-to-8-bit LUTs, blanks, syncs, pixel enable) into the Analogue Pocket APF scaler video bus. It sits directly downstream of the core top level and drives `video_rgb`/`video_de`/`video_hs`/`video_vs` toward the APF top. It generates one-pixel sync pulses from sync edges and zeroes RGB outside active video. It also measures frame geometry so the host can verify the expected video mode.

---
 rtl/xain_apf_video_adapter.sv | 154 +++++++++++++++
 tb/tb_xain_apf_video_adapter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/xain_apf_video_adapter.sv
`timescale 1ns / 1ps
// Xain'd Sleena video to APF scaler bus: de-gated RGB, one-pixel hs/vs from sync edges, geometry measurement.
// Latency one CLK after each CE_PIXEL tick; no backpressure, all outputs hold between ticks.
module xain_apf_video_adapter #(
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b1,
  parameter int HW     = 11,
  parameter int VW     = 10
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          CE_PIXEL,
  input  logic [7:0]    VIDEO_R,
  input  logic [7:0]    VIDEO_G,
  input  logic [7:0]    VIDEO_B,
  input  logic          HBLANK,
  input  logic          VBLANK,
  input  logic          HSYNC,
  input  logic          VSYNC,
  output logic [23:0]   video_rgb,
  output logic          video_de,
  output logic          video_hs,
  output logic          video_vs,
  output logic [HW-1:0] h_total,
  output logic [HW-1:0] h_active,
  output logic [VW-1:0] v_total,
  output logic [VW-1:0] v_active,
  output logic          geom_valid
);

  localparam logic [HW-1:0] H_MAX = '1;
  localparam logic [VW-1:0] V_MAX = '1;

  logic          primed;
  logic          hs_prev;
  logic          vs_prev;
  logic          hs_pend;
  logic          hs_lvl;
  logic          vs_lvl;
  logic          hs_edge;
  logic          vs_edge;
  logic          de_now;
  logic [HW-1:0] h_cnt;
  logic [HW-1:0] ha_cnt;
  logic [HW-1:0] h_line;
  logic [HW-1:0] ha_line;
  logic [HW-1:0] h_inc;
  logic [HW-1:0] ha_inc;
  logic [HW-1:0] ht_new;
  logic [HW-1:0] ha_new;
  logic          line_de;
  logic [VW-1:0] v_cnt;
  logic [VW-1:0] va_cnt;
  logic [VW-1:0] v_inc;
  logic [VW-1:0] va_fin;
  logic          have_prev;
  logic          geom_same;

  assign hs_lvl = HS_POL ? HSYNC : ~HSYNC;
  assign vs_lvl = VS_POL ? VSYNC : ~VSYNC;

  // primed stays low until the first tick after reset so a sync already asserted then is not an edge
  assign hs_edge = primed & hs_lvl & ~hs_prev;
  assign vs_edge = primed & vs_lvl & ~vs_prev;
  assign de_now  = ~HBLANK & ~VBLANK;

  assign h_inc  = (h_cnt == H_MAX) ? h_cnt : h_cnt + 1'b1;
  assign ha_inc = (de_now && (ha_cnt != H_MAX)) ? ha_cnt + 1'b1 : ha_cnt;
  assign v_inc  = (v_cnt == V_MAX) ? v_cnt : v_cnt + 1'b1;
  assign va_fin = (hs_edge && line_de && (va_cnt != V_MAX)) ? va_cnt + 1'b1 : va_cnt;

  // A line closing on the VSYNC tick itself still belongs to the frame being latched
  assign ht_new = hs_edge ? h_cnt : h_line;
  assign ha_new = (hs_edge && line_de) ? ha_cnt : ha_line;

  assign geom_same = (ht_new == h_total) && (ha_new == h_active) &&
                     (v_cnt == v_total) && (va_fin == v_active);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      primed    <= 1'b0;
      hs_prev   <= 1'b0;
      vs_prev   <= 1'b0;
      hs_pend   <= 1'b0;
      video_de  <= 1'b0;
      video_rgb <= '0;
      video_hs  <= 1'b0;
      video_vs  <= 1'b0;
    end else if (CE_PIXEL) begin
      primed    <= 1'b1;
      hs_prev   <= hs_lvl;
      vs_prev   <= vs_lvl;
      video_de  <= de_now;
      video_rgb <= de_now ? {VIDEO_R, VIDEO_G, VIDEO_B} : 24'h0;
      video_vs  <= vs_edge;
      // hs never coincides with vs on the bus: it slips one pixel and merges with any edge there
      video_hs  <= (hs_edge & ~vs_edge) | hs_pend;
      hs_pend   <= hs_edge & vs_edge;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      h_cnt   <= '0;
      ha_cnt  <= '0;
      h_line  <= '0;
      ha_line <= '0;
      line_de <= 1'b0;
    end else if (CE_PIXEL) begin
      if (hs_edge) begin
        h_line  <= h_cnt;
        // vertical-blank lines carry no de, so only lines with video update the active width
        if (line_de) begin
          ha_line <= ha_cnt;
        end
        h_cnt   <= {{(HW-1){1'b0}}, 1'b1};
        ha_cnt  <= {{(HW-1){1'b0}}, de_now};
        line_de <= de_now;
      end else begin
        h_cnt   <= h_inc;
        ha_cnt  <= ha_inc;
        line_de <= line_de | de_now;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      v_cnt      <= '0;
      va_cnt     <= '0;
      h_total    <= '0;
      h_active   <= '0;
      v_total    <= '0;
      v_active   <= '0;
      geom_valid <= 1'b0;
      have_prev  <= 1'b0;
    end else if (CE_PIXEL) begin
      if (vs_edge) begin
        h_total    <= ht_new;
        h_active   <= ha_new;
        v_total    <= v_cnt;
        v_active   <= va_fin;
        geom_valid <= have_prev & geom_same;
        have_prev  <= 1'b1;
        v_cnt      <= {{(VW-1){1'b0}}, hs_edge};
        va_cnt     <= '0;
      end else if (hs_edge) begin
        v_cnt      <= v_inc;
        va_cnt     <= va_fin;
      end
    end
  end

endmodule

// File: tb/tb_xain_apf_video_adapter.sv
`timescale 1ns / 1ps
// Directed frame sequence with random pixels/gap inputs, checked every CLK against a geometry-level model.
module tb_xain_apf_video_adapter;

  localparam int N_IDLE = 5;
  localparam int HSW    = 8;
  localparam int NF     = 15;
  localparam int RST_F  = 11;
  localparam int RST_Y  = 5;
  localparam int RST_X  = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic [7:0]  r, g, b;
  logic        hblank, vblank, hsync, vsync;
  logic [23:0] video_rgb;
  logic        video_de, video_hs, video_vs, geom_valid;
  logic [10:0] h_total, h_active;
  logic [9:0]  v_total, v_active;

  always #5 clk = ~clk;

  xain_apf_video_adapter dut (
    .CLK(clk), .RSTn(rst_n), .CE_PIXEL(ce),
    .VIDEO_R(r), .VIDEO_G(g), .VIDEO_B(b),
    .HBLANK(hblank), .VBLANK(vblank), .HSYNC(hsync), .VSYNC(vsync),
    .video_rgb(video_rgb), .video_de(video_de), .video_hs(video_hs), .video_vs(video_vs),
    .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
    .geom_valid(geom_valid)
  );

  typedef struct {
    int l;
    int a;
    int v;
    int va;
    int gap;
    int off;
  } frm_t;

  frm_t frames [NF];

  int n_assert = 0;
  int n_fail   = 0;

  logic [23:0] e_rgb;
  logic        e_de, e_hs, e_vs, e_gv;
  int          e_ht, e_ha, e_vt, e_va;
  bit          have_prev;
  int          lat_mode;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("video_de",   32'(video_de),   32'(e_de));
    chk("video_rgb",  32'(video_rgb),  32'(e_rgb));
    chk("video_hs",   32'(video_hs),   32'(e_hs));
    chk("video_vs",   32'(video_vs),   32'(e_vs));
    chk("h_total",    32'(h_total),    32'(e_ht));
    chk("h_active",   32'(h_active),   32'(e_ha));
    chk("v_total",    32'(v_total),    32'(e_vt));
    chk("v_active",   32'(v_active),   32'(e_va));
    chk("geom_valid", 32'(geom_valid), 32'(e_gv));
  endtask

  task automatic clear_model();
    e_rgb = '0; e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_gv = 1'b0;
    e_ht = 0; e_ha = 0; e_vt = 0; e_va = 0;
    have_prev = 1'b0;
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    {r, g, b} = 24'($urandom);
    hblank = 1'($urandom_range(0, 1));
    vblank = 1'($urandom_range(0, 1));
    hsync  = 1'($urandom_range(0, 1));
    vsync  = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_inputs();
    {r, g, b} = 24'($urandom);
    hblank = 1'b1; vblank = 1'b1;
    hsync  = 1'b1;                 // active-low sync, inactive
    vsync  = 1'b0;                 // active-high sync, inactive
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    clear_model();
    check_all();
    repeat (3) begin
      ce = 1'b1;
      clk_step();
      check_all();
    end
    rst_n = 1'b1;
    lat_mode = 2;
  endtask

  initial begin
    frm_t        f, pf;
    logic [23:0] pix;
    logic        n_de, n_hs, n_vs, n_gv, co;
    logic [23:0] n_rgb;
    int          nht, nha, nvt, nva, de_seen;

    frames[0]  = '{64, 40, 12, 9, 1, 0};
    frames[1]  = '{64, 40, 12, 9, 1, 0};
    frames[2]  = '{64, 40, 12, 9, 1, 0};
    frames[3]  = '{64, 40, 11, 9, 1, 0};
    frames[4]  = '{64, 40, 11, 9, 4, 0};
    frames[5]  = '{384, 256, 6, 4, 1, 0};
    frames[6]  = '{384, 256, 6, 4, 1, 0};
    frames[7]  = '{384, 256, 6, 4, 1, 0};
    frames[8]  = '{64, 40, 12, 9, 1, 5};
    frames[9]  = '{64, 40, 12, 9, 1, 5};
    frames[10] = '{64, 40, 12, 9, 1, 0};
    frames[11] = '{64, 40, 12, 9, 2, 0};
    frames[12] = '{64, 40, 12, 9, 1, 0};
    frames[13] = '{64, 40, 12, 9, 1, 0};
    frames[14] = '{64, 40, 12, 9, 1, 0};

    rst_n = 1'b0;
    ce = 1'b0;
    idle_inputs();
    clear_model();
    lat_mode = 0;
    de_seen = 0;
    pf = frames[0];

    repeat (3) begin
      ce = 1'b1;
      clk_step();
      check_all();
    end
    rst_n = 1'b1;

    for (int i = 0; i < N_IDLE; i++) begin
      idle_inputs();
      ce = 1'b1;
      clk_step();
      check_all();
    end

    for (int k = 0; k < NF; k++) begin
      f  = frames[k];
      co = (f.off == 0);
      for (int y = 0; y < f.v; y++) begin
        for (int x = 0; x < f.l; x++) begin
          if (k == RST_F && y == RST_Y && x == RST_X) mid_reset();

          pix    = 24'($urandom);
          {r, g, b} = pix;
          hblank = (x >= f.a);
          vblank = (y >= f.va);
          hsync  = !(x < HSW);
          vsync  = (y == 0 && x >= f.off) || (y >= 1 && y <= 2);

          n_de  = (x < f.a) && (y < f.va);
          n_rgb = n_de ? pix : 24'h0;
          n_vs  = (y == 0 && x == f.off);
          n_hs  = (x == 0 && !(y == 0 && co)) || (x == 1 && y == 0 && co);

          nht = e_ht; nha = e_ha; nvt = e_vt; nva = e_va; n_gv = e_gv;
          if (y == 0 && x == f.off) begin
            if (lat_mode == 0) begin
              nht = N_IDLE; nha = 0; nvt = 0; nva = 0;
            end else if (lat_mode == 2) begin
              nht = pf.l; nha = pf.a;
              nvt = pf.v - 1 - RST_Y + (f.off > 0 ? 1 : 0);
              nva = pf.va - RST_Y;
            end else begin
              nht = pf.l; nha = pf.a;
              nvt = (pf.off == 0 ? 1 : 0) + pf.v - 1 + (f.off > 0 ? 1 : 0);
              nva = pf.va;
            end
            n_gv = have_prev && nht == e_ht && nha == e_ha && nvt == e_vt && nva == e_va;
            have_prev = 1'b1;
            lat_mode  = 1;
          end

          ce = 1'b1;
          clk_step();
          e_de = n_de; e_rgb = n_rgb; e_hs = n_hs; e_vs = n_vs; e_gv = n_gv;
          e_ht = nht; e_ha = nha; e_vt = nvt; e_va = nva;
          check_all();

          if (x == 0) de_seen = 0;
          de_seen += int'(video_de);
          if (x == f.l - 1 && y < f.va && !(k == RST_F && y == RST_Y))
            chk("de_per_line", 32'(de_seen), 32'(f.a));

          for (int gp = 1; gp < f.gap; gp++) begin
            rand_inputs();
            ce = 1'b0;
            clk_step();
            check_all();
          end
        end
      end
      pf = f;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: observed still running, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
